axil_rd_ext_mch: RTL and testbench
==================================

// Module: axil_rd_ext_mch
// PURPOSE
//  AXI4-Lite read slave bridging NUM_CH word-mapped external read ports (MEM_BASE + 4*ch)
//  to a single AXI-lite read channel. Accepts up to MAX_OUTST reads in flight and keeps
//  AXI responses in request order, including error responses. External responses are
//  buffered, so ext_rsp_val never needs back-pressure. Sits between the AXI-lite
//  interconnect and the external data sources, replacing the single-port bridge.
// PARAMETERS
//  MEM_BASE    32'h10000000  byte address of channel 0; channel ch is at MEM_BASE + 4*ch
//  NUM_CH      4             number of external read ports, 1..32
//  MAX_OUTST   4             maximum accepted-but-unanswered reads, power of 2, >=2
//  DATA_WIDTH  32            AXI and external data width
//  ADDR_WIDTH  32            AXI address width
// PORTS
//  clk          in   1                  clock
//  rst_n        in   1                  asynchronous active-low reset
//  axi_araddr   in   ADDR_WIDTH         read address
//  axi_arvalid  in   1                  read address valid
//  axi_arready  out  1                  read address ready
//  axi_rdata    out  DATA_WIDTH         read data
//  axi_rresp    out  2                  2'b00 OKAY, 2'b10 SLVERR
//  axi_rvalid   out  1                  read data valid
//  axi_rready   in   1                  read data ready
//  ext_rd_req   out  NUM_CH             one-hot read strobe, one cycle per accepted read
//  ext_rsp_dat  in   DATA_WIDTH         external response data, shared by all channels
//  ext_rsp_val  in   1                  response strobe; responses return in issue order
//  ext_rsp_ovf  out  1                  sticky flag: a response arrived with none pending
//  outst_cnt    out  $clog2(MAX_OUTST)+1  current in-flight count
// BEHAVIOUR
//  - Reset: axi_arready=0, axi_rvalid=0, axi_rdata=0, axi_rresp=0, ext_rd_req=0,
//    ext_rsp_ovf=0, outst_cnt=0. All FIFOs empty.
//  - axi_arready = (outst_cnt < MAX_OUTST). It is independent of axi_arvalid.
//  - Decode: hit when araddr[1:0]==0 and the index (araddr-MEM_BASE)>>2 < NUM_CH.
//    Anything else is an error.
//  - On an AR handshake:
//    - outst_cnt increments.
//    - A tag {err} is pushed to the order FIFO (depth MAX_OUTST).
//    - On a hit, ext_rd_req[idx] pulses combinationally in the handshake cycle. On an
//      error, no strobe is issued.
//  - ext_rsp_val pushes ext_rsp_dat into the data FIFO (depth MAX_OUTST). It cannot
//    overflow while responses match requests.
//  - R output is registered from the FIFO heads. rvalid rises the cycle after the head
//    tag is present, and then:
//    - head err=1: rresp=2'b10, rdata=0. rvalid does not wait for data. Earliest rvalid
//      is 1 cycle after the AR handshake.
//    - head err=0: rvalid requires data FIFO non-empty, rresp=2'b00. Earliest rvalid is
//      1 cycle after ext_rsp_val.
//  - rvalid/rdata/rresp are held stable until axi_rready. An R handshake pops the tag,
//    pops data if err=0, and decrements outst_cnt.
//  - Simultaneous AR and R handshakes in the same cycle leave outst_cnt unchanged.
//  - Back-to-back R handshakes allowed: throughput 1 response/cycle at full occupancy.
//  - Error tag behind a pending OKAY tag waits its turn; strict ordering is never violated.
//  - ext_rsp_val while the data FIFO already holds one entry per pending hit: the data
//    is dropped and ext_rsp_ovf is set until reset.
//  - Reset mid-operation: in-flight reads are discarded. Late ext_rsp_val after reset
//    sets ext_rsp_ovf.
// STRUCTURE
//  - axil_pkg: RESP_OKAY/RESP_SLVERR localparams and the rd_tag_t typedef.
//  - Sub-module sync_fifo #(WIDTH,DEPTH) with push/pop/full/empty, async active-low
//    reset. Instantiated twice: order FIFO (WIDTH=1) and data FIFO (WIDTH=DATA_WIDTH).
//  - Top level holds the decode, in-flight counter, R output register and overflow flag.
// TESTING
//  1. Single read at 0x10000004, ext_rsp_val 2 cycles later with 0xA5A5_0001 ->
//     ext_rd_req=4'b0010 in the AR cycle; rdata=0xA5A5_0001, rresp=00.
//  2. Four back-to-back ARs to ch0..3 with rready=0 -> 5th AR stalls (arready=0);
//     four responses drain in order, one per cycle, once rready=1.
//  3. AR 0x10000004, AR 0x20000000, AR 0x10000008 -> responses in order: OKAY, SLVERR
//     (rdata=0), OKAY. No strobe for the error.
//  4. Unaligned 0x10000002 and out-of-range 0x10000010 (NUM_CH=4) -> SLVERR each,
//     ext_rd_req stays 0.
//  5. ext_rsp_val with outst_cnt=0 -> ext_rsp_ovf=1 and sticky; no rvalid produced.
//  6. rst_n dropped with 3 reads in flight -> rvalid=0, outst_cnt=0 immediately;
//     next read completes normally.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI-lite read definitions.
//   RESP_OKAY / RESP_SLVERR : AXI rresp encodings
//   rd_tag_t                : per-read ordering tag held in the order FIFO
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One tag per accepted read; err marks a decode miss answered without data.
  typedef struct packed {
    logic err;
  } rd_tag_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a first-word-fall-through head.
//   clk, rst_n        : clock, async active-low reset (pointers only)
//   push_i, wdata_i   : write strobe and data (ignored when full)
//   pop_i             : read strobe (ignored when empty)
//   rdata_o           : current head entry
//   full_o, empty_o   : occupancy flags
// DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; empty pointers hide stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/axil_rd_ext_mch.sv
// AXI4-Lite read slave fanning out to NUM_CH word-mapped external read ports.
//   clk, rst_n                     : clock, async active-low reset
//   axi_ar* / axi_r*               : AXI-lite read address and read data channels
//   ext_rd_req                     : one-hot read strobe, driven in the AR handshake cycle
//   ext_rsp_dat / ext_rsp_val      : in-order external responses, always accepted
//   ext_rsp_ovf                    : sticky, a response arrived with no hit waiting for one
//   outst_cnt                      : reads accepted but not yet answered on R
// Responses leave in request order; decode misses are answered SLVERR in their slot.
module axil_rd_ext_mch
  import axil_pkg::*;
#(
  parameter logic [31:0] MEM_BASE   = 32'h1000_0000,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          axi_araddr,
  input  logic                           axi_arvalid,
  output logic                           axi_arready,
  output logic [DATA_WIDTH-1:0]          axi_rdata,
  output logic [1:0]                     axi_rresp,
  output logic                           axi_rvalid,
  input  logic                           axi_rready,
  output logic [NUM_CH-1:0]              ext_rd_req,
  input  logic [DATA_WIDTH-1:0]          ext_rsp_dat,
  input  logic                           ext_rsp_val,
  output logic                           ext_rsp_ovf,
  output logic [$clog2(MAX_OUTST):0]     outst_cnt
);

  localparam int unsigned CW = $clog2(MAX_OUTST) + 1;
  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         pend_q, pend_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ovf_q, ovf_d;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  hit, ar_hs, r_hs, rsp_ok, load;
  rd_tag_t               tag_in, ord_head;
  logic                  ord_full, ord_empty, ord_pop;
  logic [DATA_WIDTH-1:0] dat_head;
  logic                  dat_full, dat_empty, dat_pop;

  assign ar_hs = axi_arvalid && arready_q;
  assign r_hs  = rvalid_q && axi_rready;

  // Address decode; addresses below MEM_BASE wrap to large offsets and miss.
  assign offset     = axi_araddr - ADDR_WIDTH'(MEM_BASE);
  assign hit        = (axi_araddr[1:0] == 2'b00) &&
                      (offset[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(NUM_CH));
  assign tag_in.err = !hit;
  assign ext_rd_req = (ar_hs && hit) ? (NUM_CH'(1) << offset[IW+1:2]) : '0;

  // pend_q counts hits still owed an external response; anything beyond is dropped.
  assign rsp_ok = ext_rsp_val && (pend_q != '0);

  // The R register acts as a one-entry stage: loading it pops the FIFO heads.
  assign load = !ord_empty && (ord_head.err || !dat_empty) && (!rvalid_q || axi_rready);

  sync_fifo #(.WIDTH($bits(rd_tag_t)), .DEPTH(MAX_OUTST)) u_ord_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ar_hs && !ord_full),
    .wdata_i (tag_in),
    .pop_i   (ord_pop),
    .rdata_o (ord_head),
    .full_o  (ord_full),
    .empty_o (ord_empty)
  );

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(MAX_OUTST)) u_dat_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rsp_ok && !dat_full),
    .wdata_i (ext_rsp_dat),
    .pop_i   (dat_pop),
    .rdata_o (dat_head),
    .full_o  (dat_full),
    .empty_o (dat_empty)
  );

  // Next-state for counters, AR ready, R output stage and overflow flag.
  always_comb begin
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ord_pop   = 1'b0;
    dat_pop   = 1'b0;
    ovf_d     = ovf_q | (ext_rsp_val & ~rsp_ok);

    case ({ar_hs, r_hs})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    case ({ar_hs && hit, rsp_ok})
      2'b10:   pend_d = pend_q + CW'(1);
      2'b01:   pend_d = pend_q - CW'(1);
      default: pend_d = pend_q;
    endcase

    arready_d = (cnt_d < CW'(MAX_OUTST));

    if (load) begin
      ord_pop  = 1'b1;
      dat_pop  = !ord_head.err;
      rvalid_d = 1'b1;
      rdata_d  = ord_head.err ? '0 : dat_head;
      rresp_d  = ord_head.err ? RESP_SLVERR : RESP_OKAY;
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pend_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      ovf_q     <= ovf_d;
    end
  end

  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign ext_rsp_ovf = ovf_q;
  assign outst_cnt   = cnt_q;

endmodule

// File: tb/tb_axil_rd_ext_mch.sv
// Directed bench for axil_rd_ext_mch with default parameters (4 channels, 4 outstanding).
module tb_axil_rd_ext_mch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] axi_araddr = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;
  logic [3:0]  ext_rd_req;
  logic [31:0] ext_rsp_dat = '0;
  logic        ext_rsp_val = 1'b0;
  logic        ext_rsp_ovf;
  logic [2:0]  outst_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axil_rd_ext_mch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axi_araddr  (axi_araddr),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .ext_rd_req  (ext_rd_req),
    .ext_rsp_dat (ext_rsp_dat),
    .ext_rsp_val (ext_rsp_val),
    .ext_rsp_ovf (ext_rsp_ovf),
    .outst_cnt   (outst_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One AR beat; checks the strobe in the handshake cycle.
  task automatic ar(input logic [31:0] addr, input logic [3:0] exp_req);
    axi_araddr  = addr;
    axi_arvalid = 1'b1;
    #1;
    chk("ar_ready", 32'(axi_arready), 32'd1);
    chk("ext_rd_req", 32'(ext_rd_req), 32'(exp_req));
    tick();
    axi_arvalid = 1'b0;
  endtask

  task automatic rsp(input logic [31:0] d);
    ext_rsp_dat = d;
    ext_rsp_val = 1'b1;
    tick();
    ext_rsp_val = 1'b0;
  endtask

  task automatic wait_rvalid();
    for (int i = 0; i < 20 && !axi_rvalid; i++) tick();
    chk("rvalid_timeout", 32'(axi_rvalid), 32'd1);
  endtask

  task automatic recv(input logic [31:0] exp_d, input logic [1:0] exp_r);
    wait_rvalid();
    chk("rdata", axi_rdata, exp_d);
    chk("rresp", 32'(axi_rresp), 32'(exp_r));
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_arready", 32'(axi_arready), 32'd0);
    chk("rst_rvalid", 32'(axi_rvalid), 32'd0);
    chk("rst_rdata", axi_rdata, 32'd0);
    chk("rst_rresp", 32'(axi_rresp), 32'd0);
    chk("rst_req", 32'(ext_rd_req), 32'd0);
    chk("rst_ovf", 32'(ext_rsp_ovf), 32'd0);
    chk("rst_cnt", 32'(outst_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. single read on channel 1
    ar(32'h1000_0004, 4'b0010);
    chk("t1_cnt", 32'(outst_cnt), 32'd1);
    tick();
    chk("t1_no_early_rvalid", 32'(axi_rvalid), 32'd0);
    rsp(32'hA5A5_0001);
    recv(32'hA5A5_0001, 2'b00);
    chk("t1_cnt_done", 32'(outst_cnt), 32'd0);

    // 2. fill to MAX_OUTST, stall, then drain back-to-back
    ar(32'h1000_0000, 4'b0001);
    ar(32'h1000_0004, 4'b0010);
    ar(32'h1000_0008, 4'b0100);
    ar(32'h1000_000C, 4'b1000);
    axi_araddr  = 32'h1000_0000;
    axi_arvalid = 1'b1;
    #1;
    chk("t2_stall_arready", 32'(axi_arready), 32'd0);
    chk("t2_stall_req", 32'(ext_rd_req), 32'd0);
    tick();
    axi_arvalid = 1'b0;
    chk("t2_cnt_full", 32'(outst_cnt), 32'd4);
    rsp(32'hD000_0000);
    rsp(32'hD000_0001);
    rsp(32'hD000_0002);
    rsp(32'hD000_0003);
    wait_rvalid();
    chk("t2_d0", axi_rdata, 32'hD000_0000);
    axi_rready = 1'b1;
    tick();
    chk("t2_v1", 32'(axi_rvalid), 32'd1);
    chk("t2_d1", axi_rdata, 32'hD000_0001);
    tick();
    chk("t2_v2", 32'(axi_rvalid), 32'd1);
    chk("t2_d2", axi_rdata, 32'hD000_0002);
    tick();
    chk("t2_v3", 32'(axi_rvalid), 32'd1);
    chk("t2_d3", axi_rdata, 32'hD000_0003);
    tick();
    axi_rready = 1'b0;
    chk("t2_drained", 32'(axi_rvalid), 32'd0);
    chk("t2_cnt_zero", 32'(outst_cnt), 32'd0);

    // 3. error between two hits keeps its slot
    ar(32'h1000_0004, 4'b0010);
    ar(32'h2000_0000, 4'b0000);
    ar(32'h1000_0008, 4'b0100);
    rsp(32'h3333_0001);
    rsp(32'h3333_0002);
    recv(32'h3333_0001, 2'b00);
    recv(32'h0000_0000, 2'b10);
    recv(32'h3333_0002, 2'b00);

    // 4. unaligned and out-of-range
    ar(32'h1000_0002, 4'b0000);
    ar(32'h1000_0010, 4'b0000);
    recv(32'h0000_0000, 2'b10);
    recv(32'h0000_0000, 2'b10);
    chk("t4_cnt_zero", 32'(outst_cnt), 32'd0);

    // 5. response with nothing pending
    rsp(32'hDEAD_BEEF);
    chk("t5_ovf", 32'(ext_rsp_ovf), 32'd1);
    tick();
    tick();
    chk("t5_ovf_sticky", 32'(ext_rsp_ovf), 32'd1);
    chk("t5_no_rvalid", 32'(axi_rvalid), 32'd0);

    // 6. reset with three reads in flight, one already presented
    ar(32'h1000_0000, 4'b0001);
    ar(32'h1000_0004, 4'b0010);
    ar(32'h1000_0008, 4'b0100);
    rsp(32'h6666_0000);
    wait_rvalid();
    chk("t6_cnt_pre", 32'(outst_cnt), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_rvalid", 32'(axi_rvalid), 32'd0);
    chk("t6_cnt", 32'(outst_cnt), 32'd0);
    chk("t6_arready", 32'(axi_arready), 32'd0);
    chk("t6_ovf_clr", 32'(ext_rsp_ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rsp(32'h7777_0000);
    chk("t6_late_ovf", 32'(ext_rsp_ovf), 32'd1);
    chk("t6_late_no_rvalid", 32'(axi_rvalid), 32'd0);
    ar(32'h1000_000C, 4'b1000);
    rsp(32'hC0DE_000C);
    recv(32'hC0DE_000C, 2'b00);
    chk("t6_cnt_end", 32'(outst_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
